// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load,
// shift enable and frame start/end strobes.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic active, last, accept;

  assign active = (state_q == SHIFT);
  assign last   = (cnt_q == LAST);

  // Ready on the last enabled bit lets the next word follow with no gap
  assign load_ready = !active || (last && shift_en);
  assign accept     = load_valid && load_ready;

  assign sout_valid  = active;
  assign busy        = active;
  assign frame_start = active && (cnt_q == '0);
  assign frame_end   = active && last;
  assign sout = active &&
    (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = SHIFT;
      shreg_d = d;
      cnt_d   = '0;
    end else if (active && shift_en) begin
      if (last) begin
        state_d = IDLE;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        shreg_d = MSB_FIRST ? (shreg_q << 1)
                            : (shreg_q >> 1);
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: vector table, hand-written corner sequences and a
// randomized run against a word/bit-position reference model.
module tb_piso_tx;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] d;
  logic       lv, se;
  logic       lr4, so4, sv4, fs4, fe4, bz4;
  logic       lrl, sol, svl, fsl, fel, bzl;

  logic [7:0] d8;
  logic       lv8, se8;
  logic       lr8, so8, sv8, fs8, fe8, bz8;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .clear(clear), .d(d), .load_valid(lv),
    .load_ready(lr4), .shift_en(se), .sout(so4),
    .sout_valid(sv4), .frame_start(fs4), .frame_end(fe4),
    .busy(bz4)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u4l (
    .clk(clk), .clear(clear), .d(d), .load_valid(lv),
    .load_ready(lrl), .shift_en(se), .sout(sol),
    .sout_valid(svl), .frame_start(fsl), .frame_end(fel),
    .busy(bzl)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u8 (
    .clk(clk), .clear(clear), .d(d8), .load_valid(lv8),
    .load_ready(lr8), .shift_en(se8), .sout(so8),
    .sout_valid(sv8), .frame_start(fs8), .frame_end(fe8),
    .busy(bz8)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] d;
    logic lv, se;
    logic so, sv, fs, fe, lr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic [3:0] dd, logic l, logic s,
                             logic o, logic a, logic fs,
                             logic fe, logic r);
    vec_t x;
    x.d = dd; x.lv = l; x.se = s;
    x.so = o; x.sv = a; x.fs = fs; x.fe = fe; x.lr = r;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #3 clear = 1'b1;
    step();
  endtask

  // Reference model: current word, bits sent so far, frame active
  logic [3:0] m_word;
  int         m_pos;
  bit         m_act;

  function automatic logic m_bit(bit msb);
    if (!m_act) return 1'b0;
    return msb ? m_word[3 - m_pos] : m_word[m_pos];
  endfunction

  initial begin
    d = '0; lv = 0; se = 0;
    d8 = '0; lv8 = 0; se8 = 0;
    #2;
    chk("rst_lr", lr4, 1);
    chk("rst_sout", so4, 0);
    chk("rst_sv", sv4, 0);
    chk("rst_fs", fs4, 0);
    chk("rst_fe", fe4, 0);
    chk("rst_busy", bz4, 0);
    chk("rst_lr8", lr8, 1);
    do_reset();

    // single word 0011
    tbl.push_back(v(4'h3,1,1, 0,0,0,0,1));
    tbl.push_back(v(4'h0,0,1, 0,1,1,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 0,0,0,0,1));
    // back-to-back 0111 then 1011
    tbl.push_back(v(4'h7,1,1, 0,0,0,0,1));
    tbl.push_back(v(4'hB,1,1, 0,1,1,0,0));
    tbl.push_back(v(4'hB,1,1, 1,1,0,0,0));
    tbl.push_back(v(4'hB,1,1, 1,1,0,0,0));
    tbl.push_back(v(4'hB,1,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 1,1,1,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 0,0,0,0,1));
    // stall on bit 2 of 1001
    tbl.push_back(v(4'h9,1,1, 0,0,0,0,1));
    tbl.push_back(v(4'h0,0,1, 1,1,1,0,0));
    tbl.push_back(v(4'h0,0,0, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,0, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,0, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 0,0,0,0,1));
    // busy reject: 0001 offered during 1111
    tbl.push_back(v(4'hF,1,1, 0,0,0,0,1));
    tbl.push_back(v(4'h0,0,1, 1,1,1,0,0));
    tbl.push_back(v(4'h1,1,1, 1,1,0,0,0));
    tbl.push_back(v(4'h1,1,1, 1,1,0,0,0));
    tbl.push_back(v(4'h1,1,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 0,1,1,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 0,1,0,0,0));
    tbl.push_back(v(4'h0,0,1, 1,1,0,1,1));
    tbl.push_back(v(4'h0,0,1, 0,0,0,0,1));

    foreach (tbl[i]) begin
      d = tbl[i].d; lv = tbl[i].lv; se = tbl[i].se;
      @(negedge clk);
      chk($sformatf("tbl%0d_sout", i), so4, tbl[i].so);
      chk($sformatf("tbl%0d_sv", i), sv4, tbl[i].sv);
      chk($sformatf("tbl%0d_busy", i), bz4, tbl[i].sv);
      chk($sformatf("tbl%0d_fs", i), fs4, tbl[i].fs);
      chk($sformatf("tbl%0d_fe", i), fe4, tbl[i].fe);
      chk($sformatf("tbl%0d_lr", i), lr4, tbl[i].lr);
      step();
    end

    // LSB first: 1011 -> 1,1,0,1
    begin
      logic [3:0] exp_l;
      exp_l = 4'b1011;
      d = 4'hB; lv = 1; se = 1;
      step();
      lv = 0; d = 4'h0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk($sformatf("lsb_bit%0d", k), sol, exp_l[k]);
        chk($sformatf("lsb_fe%0d", k), fel, k == 3);
        step();
      end
      @(negedge clk);
      chk("lsb_idle", svl, 0);
      step();
    end

    // WIDTH=8: 0xA5 -> 1,0,1,0,0,1,0,1
    begin
      logic [7:0] exp8;
      exp8 = 8'hA5;
      d8 = 8'hA5; lv8 = 1; se8 = 1;
      step();
      lv8 = 0; d8 = 8'h00;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        chk($sformatf("w8_bit%0d", k), so8, exp8[7 - k]);
        chk($sformatf("w8_fs%0d", k), fs8, k == 0);
        chk($sformatf("w8_fe%0d", k), fe8, k == 7);
        chk($sformatf("w8_lr%0d", k), lr8, k == 7);
        step();
      end
      @(negedge clk);
      chk("w8_idle", sv8, 0);
      step();
    end

    // reset mid-frame after bit 2 of 1011
    d = 4'hB; lv = 1; se = 1;
    step();
    lv = 0; d = 4'h0;
    @(negedge clk);
    chk("rmf_bit1", so4, 1);
    step();
    @(negedge clk);
    chk("rmf_bit2", so4, 0);
    #1 clear = 1'b0;
    #1;
    chk("rmf_lr", lr4, 1);
    chk("rmf_sout", so4, 0);
    chk("rmf_sv", sv4, 0);
    chk("rmf_fe", fe4, 0);
    step();
    #3 clear = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rmf_post%0d", k), sv4, 0);
      step();
    end

    // randomized run against the reference model
    do_reset();
    m_act = 0; m_pos = 0; m_word = '0;
    for (int n = 0; n < 3000; n++) begin
      logic e_lr;
      d  = 4'($urandom);
      lv = ($urandom_range(0, 9) < 6);
      se = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      e_lr = !m_act || (m_pos == 3 && se);
      chk("rnd_sout", so4, m_bit(1'b1));
      chk("rnd_sout_lsb", sol, m_bit(1'b0));
      chk("rnd_sv", sv4, m_act);
      chk("rnd_fs", fs4, m_act && m_pos == 0);
      chk("rnd_fe", fe4, m_act && m_pos == 3);
      chk("rnd_lr", lr4, e_lr);
      chk("rnd_lr_lsb", lrl, e_lr);
      if (lv && e_lr) begin
        m_word = d; m_pos = 0; m_act = 1;
      end else if (m_act && se) begin
        if (m_pos == 3) m_act = 0;
        else m_pos++;
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
